// File: rtl/cptra_ss_boot_seq.sv
// rtl/cptra_ss_boot_seq.sv - power-good / reset sequencer with boot handshake supervision
module cptra_ss_boot_seq #(
    parameter int unsigned PWRGOOD_DLY  = 16,
    parameter int unsigned WARM_RST_CYC = 8,
    parameter int unsigned FUSE_TIMEOUT = 4096
) (
    input  logic       cptra_ss_clk_i,
    input  logic       cptra_ss_rst_i,
    input  logic       power_on_req_i,
    input  logic       warm_rst_req_i,
    input  logic       ready_for_fuses_i,
    input  logic       cptra_ss_all_error_fatal_i,
    input  logic       fatal_rst_en_i,
    output logic       cptra_ss_pwrgood_o,
    output logic       cptra_ss_rst_b_o,
    output logic [2:0] seq_state_o,
    output logic       boot_timeout_o,
    output logic [7:0] warm_rst_cnt_o
);

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        PWR_UP    = 3'd1,
        BOOT_WAIT = 3'd2,
        RUN       = 3'd3,
        WARM_RST  = 3'd4,
        FAULT     = 3'd5
    } state_e;

    localparam logic [15:0] PWR_LAST  = 16'(PWRGOOD_DLY - 1);
    localparam logic [15:0] WARM_LAST = 16'(WARM_RST_CYC - 1);
    localparam logic [15:0] FUSE_LAST = 16'(FUSE_TIMEOUT - 1);

    state_e      state;
    logic [15:0] cnt;

    assign seq_state_o = state;

    // Outputs are updated on the same edge as the state they belong to.
    always_ff @(posedge cptra_ss_clk_i) begin
        if (cptra_ss_rst_i) begin
            state              <= OFF;
            cnt                <= '0;
            cptra_ss_pwrgood_o <= 1'b0;
            cptra_ss_rst_b_o   <= 1'b0;
            boot_timeout_o     <= 1'b0;
            warm_rst_cnt_o     <= '0;
        end else if (state != OFF && !power_on_req_i) begin
            state              <= OFF;
            cnt                <= '0;
            cptra_ss_pwrgood_o <= 1'b0;
            cptra_ss_rst_b_o   <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    if (power_on_req_i) begin
                        state              <= PWR_UP;
                        cnt                <= '0;
                        cptra_ss_pwrgood_o <= 1'b1;
                        cptra_ss_rst_b_o   <= 1'b0;
                    end
                end
                PWR_UP: begin
                    if (cnt == PWR_LAST) begin
                        state            <= BOOT_WAIT;
                        cnt              <= '0;
                        cptra_ss_rst_b_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                BOOT_WAIT: begin
                    // A ready seen on the last allowed sample still wins over expiry.
                    if (ready_for_fuses_i) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else if (cnt == FUSE_LAST) begin
                        state            <= FAULT;
                        cnt              <= '0;
                        cptra_ss_rst_b_o <= 1'b0;
                        boot_timeout_o   <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RUN: begin
                    if (warm_rst_req_i || (cptra_ss_all_error_fatal_i && fatal_rst_en_i)) begin
                        state            <= WARM_RST;
                        cnt              <= '0;
                        cptra_ss_rst_b_o <= 1'b0;
                        if (warm_rst_cnt_o != 8'hff) begin
                            warm_rst_cnt_o <= warm_rst_cnt_o + 8'd1;
                        end
                    end
                end
                WARM_RST: begin
                    if (cnt == WARM_LAST) begin
                        state            <= BOOT_WAIT;
                        cnt              <= '0;
                        cptra_ss_rst_b_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                FAULT: begin
                end
                default: begin
                    state              <= OFF;
                    cnt                <= '0;
                    cptra_ss_pwrgood_o <= 1'b0;
                    cptra_ss_rst_b_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cptra_ss_boot_seq.sv
// tb/tb_cptra_ss_boot_seq.sv - self-checking bench for cptra_ss_boot_seq
module tb_cptra_ss_boot_seq;

    localparam int D  = 16;
    localparam int W  = 8;
    localparam int FT = 64;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       por   = 1'b0;
    logic       warm  = 1'b0;
    logic       rdy   = 1'b0;
    logic       fatal = 1'b0;
    logic       fen   = 1'b0;
    logic       pg;
    logic       rb;
    logic [2:0] st;
    logic       to;
    logic [7:0] wc;

    int checks = 0;
    int errors = 0;
    bit exp_to = 1'b0;
    int exp_wc = 0;

    always #5 clk = ~clk;

    cptra_ss_boot_seq #(
        .PWRGOOD_DLY (D),
        .WARM_RST_CYC(W),
        .FUSE_TIMEOUT(FT)
    ) dut (
        .cptra_ss_clk_i            (clk),
        .cptra_ss_rst_i            (rst),
        .power_on_req_i            (por),
        .warm_rst_req_i            (warm),
        .ready_for_fuses_i         (rdy),
        .cptra_ss_all_error_fatal_i(fatal),
        .fatal_rst_en_i            (fen),
        .cptra_ss_pwrgood_o        (pg),
        .cptra_ss_rst_b_o          (rb),
        .seq_state_o               (st),
        .boot_timeout_o            (to),
        .warm_rst_cnt_o            (wc)
    );

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp(input string tag, input string name, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, name, obs, exp);
        end
    endtask

    // Expected outputs come from the state table plus the bench's own counters.
    task automatic expect_st(input string tag, input int s);
        cmp(tag, "state",    8'(st), 8'(s));
        cmp(tag, "pwrgood",  8'(pg), (s != 0) ? 8'd1 : 8'd0);
        cmp(tag, "rst_b",    8'(rb), (s == 2 || s == 3) ? 8'd1 : 8'd0);
        cmp(tag, "timeout",  8'(to), 8'(exp_to));
        cmp(tag, "warm_cnt", wc,     8'(exp_wc));
    endtask

    task automatic note_warm();
        exp_wc = (exp_wc < 255) ? exp_wc + 1 : 255;
    endtask

    task automatic boot_to_run(input string tag);
        int k;
        k = int'($urandom_range(0, FT - 2));
        tick(k);
        expect_st(tag, 2);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        expect_st(tag, 3);
    endtask

    task automatic warm_cycle(input string tag, input bit use_fatal);
        if (use_fatal) begin
            fen   = 1'b1;
            fatal = 1'b1;
        end else begin
            warm = 1'b1;
        end
        tick(1);
        warm  = 1'b0;
        fatal = 1'b0;
        fen   = 1'b0;
        note_warm();
        expect_st(tag, 4);
        tick(W - 1);
        expect_st(tag, 4);
        tick(1);
        expect_st(tag, 2);
    endtask

    initial begin
        tick(3);
        expect_st("reset", 0);
        rst = 1'b0;
        tick(5);
        expect_st("idle", 0);

        // cold boot
        por = 1'b1;
        tick(1);
        expect_st("pwrup_first", 1);
        tick(D - 1);
        expect_st("pwrup_last", 1);
        tick(1);
        expect_st("boot_wait", 2);
        boot_to_run("cold_run");

        // warm reset, then ignored warm requests outside RUN
        warm_cycle("warm", 1'b0);
        warm = 1'b1;
        tick(1);
        warm = 1'b0;
        expect_st("warm_in_bw", 2);
        rdy  = 1'b1;
        warm = 1'b1;
        tick(1);
        rdy  = 1'b0;
        warm = 1'b0;
        expect_st("rdy_and_warm", 3);
        tick(2);
        expect_st("warm_dropped", 3);

        // fatal handling
        warm_cycle("fatal_pulse", 1'b1);
        boot_to_run("fatal_rec");
        fen   = 1'b0;
        fatal = 1'b1;
        tick(5);
        expect_st("fatal_masked", 3);
        fen = 1'b1;
        tick(1);
        note_warm();
        expect_st("fatal_level", 4);
        tick(W);
        expect_st("fatal_bw", 2);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        expect_st("fatal_rerun", 3);
        tick(1);
        note_warm();
        expect_st("fatal_persist", 4);
        fatal = 1'b0;
        fen   = 1'b0;
        tick(W);
        expect_st("fatal_done", 2);

        // boot timeout
        tick(FT - 1);
        expect_st("pre_timeout", 2);
        tick(1);
        exp_to = 1'b1;
        expect_st("timeout", 5);
        warm = 1'b1;
        tick(1);
        warm = 1'b0;
        expect_st("fault_hold", 5);
        por = 1'b0;
        tick(1);
        expect_st("pwrdown_fault", 0);

        // power-down during the power-good delay
        tick(2);
        por = 1'b1;
        tick(1);
        expect_st("abort_pwrup", 1);
        tick(4);
        por = 1'b0;
        tick(1);
        expect_st("abort_off", 0);
        por = 1'b1;
        tick(1);
        expect_st("retry_pwrup", 1);
        tick(D - 1);
        expect_st("retry_last", 1);
        tick(1);
        expect_st("retry_bw", 2);
        boot_to_run("retry_run");

        // randomized warm/fatal train up to and past saturation
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap   = int'($urandom_range(0, 3));
            fatal = 1'($urandom_range(0, 1));
            tick(gap);
            fatal = 1'b0;
            expect_st("sat_idle", 3);
            warm_cycle("sat_warm", 1'($urandom_range(0, 1)));
            boot_to_run("sat_run");
        end
        cmp("saturated", "warm_cnt", wc, 8'd255);

        // reset in the middle of a warm reset
        warm = 1'b1;
        tick(1);
        warm = 1'b0;
        note_warm();
        expect_st("mid_warm", 4);
        tick(3);
        rst = 1'b1;
        tick(1);
        exp_to = 1'b0;
        exp_wc = 0;
        expect_st("rst_mid_warm", 0);
        rst = 1'b0;
        por = 1'b0;
        tick(2);
        expect_st("rst_after", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
